// File: rtl/dmg_dma_pkg.sv
// Shared definitions for the DMG OAM DMA sequencer: state encoding, bus map constants and the
// echo-RAM source remap.
package dmg_dma_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StXfer  = 2'd2,
    StDrain = 2'd3
  } dma_state_e;

  localparam int unsigned OAM_LEN   = 160;
  localparam logic [7:0]  ECHO_BASE = 8'hE0;
  localparam logic [7:0]  VRAM_LO   = 8'h80;
  localparam logic [7:0]  VRAM_HI   = 8'h9F;

  // E0..FF is the echo of C0..DF
  function automatic logic [7:0] eff_src_hi(input logic [7:0] hi);
    return (hi >= ECHO_BASE) ? (hi - 8'h20) : hi;
  endfunction

endpackage

// File: rtl/oam_dma_ctl_if.sv
// CPU/source-bus/OAM-side signal bundle for the OAM DMA sequencer.
interface oam_dma_ctl_if;
  logic        wr_ff46;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic [7:0]  src_data;
  logic        dma_rd;
  logic [15:0] dma_addr;
  logic        oam_wr;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_data;
  logic        busy;
  logic        block_ext;
  logic        block_vram;

  modport master (
    output wr_ff46, din, src_data,
    input  dout, dma_rd, dma_addr, oam_wr, oam_addr, oam_data, busy, block_ext, block_vram
  );

  modport slave (
    input  wr_ff46, din, src_data,
    output dout, dma_rd, dma_addr, oam_wr, oam_addr, oam_data, busy, block_ext, block_vram
  );
endinterface

// File: rtl/oam_dma_counter.sv
// Source byte index for the OAM DMA: sync clear, increment enable and terminal count at N_BYTES-1.
module oam_dma_counter #(
  parameter int unsigned N_BYTES = 160
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       clr_i,
  input  logic       inc_i,
  output logic [7:0] idx_o,
  output logic       tc_o
);

  // Nine bits so a 256-byte copy reaches its terminal count without wrapping
  logic [8:0] idx_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      idx_q <= '0;
    end else if (clr_i) begin
      idx_q <= '0;
    end else if (inc_i) begin
      idx_q <= idx_q + 9'd1;
    end
  end

  assign idx_o = idx_q[7:0];
  assign tc_o  = (idx_q == 9'(N_BYTES - 1));

endmodule

// File: rtl/oam_dma_ctl.sv
// OAM DMA sequencer: FF46 write starts an N_BYTES copy from {FF46,00} into OAM, with a one-cycle
// read-to-write pipeline and source/VRAM bus arbitration.
module oam_dma_ctl
  import dmg_dma_pkg::*;
#(
  parameter int unsigned N_BYTES = OAM_LEN
) (
  input logic         clk,
  input logic         nreset,
  oam_dma_ctl_if.slave bus
);

  dma_state_e state_q;
  logic [7:0] src_hi_q;
  logic [7:0] dout_q;
  logic [7:0] data_q;
  logic [7:0] wr_idx_q;
  logic       wr_pend_q;
  logic       busy_q;

  logic [7:0] idx;
  logic       tc;
  logic [7:0] hi_eff;
  logic       xfer;
  logic       vram_src;

  assign xfer   = (state_q == StXfer);
  assign hi_eff = eff_src_hi(src_hi_q);

  oam_dma_counter #(
    .N_BYTES (N_BYTES)
  ) u_counter (
    .clk    (clk),
    .nreset (nreset),
    .clr_i  (bus.wr_ff46 || (state_q == StStart)),
    .inc_i  (xfer),
    .idx_o  (idx),
    .tc_o   (tc)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q   <= StIdle;
      src_hi_q  <= '0;
      dout_q    <= '0;
      data_q    <= '0;
      wr_idx_q  <= '0;
      wr_pend_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      // The read of the current cycle is captured even on a restart edge, so it lands in START
      wr_pend_q <= xfer;
      if (xfer) begin
        data_q   <= bus.src_data;
        wr_idx_q <= idx;
      end

      if (bus.wr_ff46) begin
        dout_q   <= bus.din;
        src_hi_q <= bus.din;
        state_q  <= StStart;
        // busy_q is already 1 in XFER/DRAIN, 0 in IDLE, and held across repeated STARTs
      end else begin
        case (state_q)
          StStart: begin
            state_q <= StXfer;
            busy_q  <= 1'b1;
          end
          StXfer: begin
            if (tc) state_q <= StDrain;
          end
          StDrain: begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign vram_src = (hi_eff >= VRAM_LO) && (hi_eff <= VRAM_HI);

  assign bus.dout       = dout_q;
  assign bus.dma_rd     = xfer;
  assign bus.dma_addr   = {hi_eff, idx};
  assign bus.oam_wr     = wr_pend_q;
  assign bus.oam_addr   = wr_idx_q;
  assign bus.oam_data   = data_q;
  assign bus.busy       = busy_q;
  assign bus.block_vram = busy_q && vram_src;
  assign bus.block_ext  = busy_q && !vram_src;

endmodule

// File: tb/tb_oam_dma_ctl.sv
// Directed bench for oam_dma_ctl: OAM writes are checked against a scoreboard of expected
// (index, byte) pairs pushed when each FF46 write is issued.
module tb_oam_dma_ctl;

  localparam int unsigned N = 160;

  logic clk;
  logic nreset;
  int   checks;
  int   failures;

  logic [15:0] exp_q[$];

  oam_dma_ctl_if bus_if ();

  oam_dma_ctl #(
    .N_BYTES (N)
  ) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [7:0] hi, input logic [7:0] lo);
    return hi ^ (lo * 8'd3) ^ 8'hA5;
  endfunction

  // Source memory model answers whatever address the DMA presents
  assign bus_if.src_data = mem_byte(bus_if.dma_addr[15:8], bus_if.dma_addr[7:0]);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] v);
    bus_if.wr_ff46 = 1'b1;
    bus_if.din     = v;
    tick();
    bus_if.wr_ff46 = 1'b0;
  endtask

  task automatic push_exp(input logic [7:0] hi, input int count);
    for (int i = 0; i < count; i++) begin
      exp_q.push_back({8'(i), mem_byte(hi, 8'(i))});
    end
  endtask

  task automatic wait_idle(input string tag);
    int guard;
    guard = 0;
    while ((bus_if.busy || bus_if.oam_wr || bus_if.dma_rd) && guard < 400) begin
      tick();
      guard++;
    end
    check({tag, "_idle_timeout"}, 32'(guard >= 400), 32'd0);
    check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_dout"}, 32'(bus_if.dout), 32'h0);
    check({tag, "_dma_rd"}, 32'(bus_if.dma_rd), 32'h0);
    check({tag, "_dma_addr"}, 32'(bus_if.dma_addr), 32'h0);
    check({tag, "_oam_wr"}, 32'(bus_if.oam_wr), 32'h0);
    check({tag, "_oam_addr"}, 32'(bus_if.oam_addr), 32'h0);
    check({tag, "_oam_data"}, 32'(bus_if.oam_data), 32'h0);
    check({tag, "_busy"}, 32'(bus_if.busy), 32'h0);
    check({tag, "_block_ext"}, 32'(bus_if.block_ext), 32'h0);
    check({tag, "_block_vram"}, 32'(bus_if.block_vram), 32'h0);
  endtask

  // Scoreboard: every OAM write must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (bus_if.oam_wr) begin
      if (exp_q.size() == 0) begin
        check("oam_unexpected_wr", {24'h0, bus_if.oam_addr}, 32'hFFFF_FFFF);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        check("oam_wr", {16'h0, bus_if.oam_addr, bus_if.oam_data}, {16'h0, e});
      end
    end
  end

  initial begin
    checks         = 0;
    failures       = 0;
    nreset         = 1'b1;
    bus_if.wr_ff46 = 1'b0;
    bus_if.din     = 8'h00;
    #1 nreset = 1'b0;
    #1 check_zero("rst");
    @(negedge clk);
    nreset = 1'b1;
    tick();
    tick();

    // Full copy from C1xx
    push_exp(8'hC1, N);
    do_write(8'hC1);
    check("c1_start_busy", 32'(bus_if.busy), 32'd0);
    check("c1_start_rd", 32'(bus_if.dma_rd), 32'd0);
    check("c1_dout", 32'(bus_if.dout), 32'hC1);
    for (int k = 1; k <= int'(N); k++) begin
      tick();
      check("c1_rd", 32'(bus_if.dma_rd), 32'd1);
      check("c1_addr", 32'(bus_if.dma_addr), 32'hC100 + 32'(k - 1));
      check("c1_busy", 32'(bus_if.busy), 32'd1);
    end
    tick();
    check("c1_drain_busy", 32'(bus_if.busy), 32'd1);
    check("c1_drain_rd", 32'(bus_if.dma_rd), 32'd0);
    check("c1_drain_wr", 32'(bus_if.oam_wr), 32'd1);
    check("c1_drain_addr", 32'(bus_if.oam_addr), 32'd159);
    tick();
    check("c1_end_busy", 32'(bus_if.busy), 32'd0);
    check("c1_end_wr", 32'(bus_if.oam_wr), 32'd0);
    check("c1_sb_empty", 32'(exp_q.size()), 32'd0);

    // VRAM source blocks VRAM only
    push_exp(8'h85, N);
    do_write(8'h85);
    tick();
    check("v85_block_vram", 32'(bus_if.block_vram), 32'd1);
    check("v85_block_ext", 32'(bus_if.block_ext), 32'd0);
    wait_idle("v85");
    check("v85_idle_vram", 32'(bus_if.block_vram), 32'd0);

    // Low ROM source blocks external bus only
    push_exp(8'h40, N);
    do_write(8'h40);
    tick();
    check("x40_block_vram", 32'(bus_if.block_vram), 32'd0);
    check("x40_block_ext", 32'(bus_if.block_ext), 32'd1);
    wait_idle("x40");
    check("x40_idle_ext", 32'(bus_if.block_ext), 32'd0);

    // Echo RAM remap
    push_exp(8'hDE, N);
    do_write(8'hFE);
    check("fe_dout", 32'(bus_if.dout), 32'hFE);
    tick();
    check("fe_addr", 32'(bus_if.dma_addr), 32'hDE00);
    check("fe_block_ext", 32'(bus_if.block_ext), 32'd1);
    wait_idle("fe");

    // Restart mid-transfer at E50
    push_exp(8'hC0, 49);
    do_write(8'hC0);
    for (int k = 1; k <= 49; k++) begin
      tick();
      check("rs_busy_c0", 32'(bus_if.busy), 32'd1);
    end
    push_exp(8'hD0, N);
    do_write(8'hD0);
    check("rs_start_busy", 32'(bus_if.busy), 32'd1);
    check("rs_start_rd", 32'(bus_if.dma_rd), 32'd0);
    check("rs_start_wr", 32'(bus_if.oam_wr), 32'd1);
    check("rs_start_wr_idx", 32'(bus_if.oam_addr), 32'd48);
    check("rs_dout", 32'(bus_if.dout), 32'hD0);
    tick();
    check("rs_first_rd", 32'(bus_if.dma_rd), 32'd1);
    check("rs_first_addr", 32'(bus_if.dma_addr), 32'hD000);
    check("rs_first_busy", 32'(bus_if.busy), 32'd1);
    check("rs_no_wr", 32'(bus_if.oam_wr), 32'd0);
    wait_idle("rs");

    // Back-to-back FF46 writes repeat START once
    push_exp(8'h34, N);
    do_write(8'h12);
    check("b2b_s1_busy", 32'(bus_if.busy), 32'd0);
    do_write(8'h34);
    check("b2b_s2_busy", 32'(bus_if.busy), 32'd0);
    check("b2b_s2_rd", 32'(bus_if.dma_rd), 32'd0);
    tick();
    check("b2b_rd", 32'(bus_if.dma_rd), 32'd1);
    check("b2b_addr", 32'(bus_if.dma_addr), 32'h3400);
    check("b2b_busy", 32'(bus_if.busy), 32'd1);
    wait_idle("b2b");

    // Async reset mid-transfer at E80
    push_exp(8'hC1, 78);
    do_write(8'hC1);
    for (int k = 1; k <= 80; k++) tick();
    nreset = 1'b0;
    #1 check_zero("mid_rst");
    check("mid_rst_sb_empty", 32'(exp_q.size()), 32'd0);
    #20;
    @(negedge clk);
    nreset = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    check_zero("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
